// File: rtl/elevator_scheduler.sv
// Single-car elevator scheduler: a FIFO of park-in/take-out jobs served one at a time,
// moving one floor per cycle and holding short of a floor under a leak alarm.
module elevator_scheduler #(
    parameter int QDEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_type,
    input  logic [15:0] req_plate,
    input  logic [2:0]  req_floor,
    input  logic        leakage,
    input  logic [2:0]  leakage_floor,
    output logic        req_ready,
    output logic        reject,
    output logic [2:0]  current_floor,
    output logic [15:0] moving,
    output logic        busy,
    output logic        done,
    output logic [2:0]  done_floor,
    output logic        stall,
    output logic [2:0]  queue_count,
    output logic [1:0]  state
);

    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        TO_PICK = 2'b01,
        TO_DROP = 2'b10
    } state_t;

    state_t             state_q;
    logic [19:0]        fifo_mem [QDEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [2:0]         pick_r;
    logic [2:0]         drop_r;
    logic [15:0]        plate_r;

    logic               push;
    logic               pop;
    logic [19:0]        head;
    logic [2:0]         target;
    logic [2:0]         next_floor;
    logic               at_target;
    logic               blocked;

    assign req_ready   = (count != CNT_W'(QDEPTH));
    assign push        = req_valid && req_ready && (req_floor != 3'd0);
    assign pop         = (state_q == IDLE) && (count != '0);
    assign head        = fifo_mem[rd_ptr];
    assign queue_count = 3'(count);
    assign state       = state_q;
    assign busy        = (state_q != IDLE);

    // Entries hold {type, plate, floor}; pick/drop floors are decoded when the job is popped.
    always_ff @(posedge clock) begin
        if (push)
            fifo_mem[wr_ptr] <= {req_type, req_plate, req_floor};
        if (pop) begin
            plate_r <= head[18:3];
            pick_r  <= head[19] ? head[2:0] : 3'd0;
            drop_r  <= head[19] ? 3'd0 : head[2:0];
        end
    end

    always_comb begin
        target     = (state_q == TO_PICK) ? pick_r : drop_r;
        at_target  = (current_floor == target);
        next_floor = (target > current_floor) ? current_floor + 3'd1 : current_floor - 3'd1;
        blocked    = leakage && (leakage_floor != 3'd0) && (next_floor == leakage_floor);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            current_floor <= 3'd0;
            moving        <= 16'd0;
            reject        <= 1'b0;
            done          <= 1'b0;
            done_floor    <= 3'd0;
            stall         <= 1'b0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
        end else begin
            reject <= req_valid && req_ready && (req_floor == 3'd0);
            done   <= 1'b0;
            stall  <= 1'b0;

            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)
                count <= count + CNT_W'(1);
            else if (pop && !push)
                count <= count - CNT_W'(1);

            case (state_q)
                IDLE: begin
                    if (pop)
                        state_q <= TO_PICK;
                end
                TO_PICK, TO_DROP: begin
                    if (at_target) begin
                        if (state_q == TO_PICK) begin
                            moving  <= plate_r;
                            state_q <= TO_DROP;
                        end else begin
                            moving     <= 16'd0;
                            done       <= 1'b1;
                            done_floor <= drop_r;
                            state_q    <= IDLE;
                        end
                    end else if (blocked) begin
                        stall <= 1'b1;
                    end else begin
                        current_floor <= next_floor;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_elevator_scheduler.sv
// Directed bench for elevator_scheduler; a monitor scoreboards pickups and unloads.
module tb_elevator_scheduler;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_type = 1'b0;
    logic [15:0] req_plate = 16'd0;
    logic [2:0]  req_floor = 3'd0;
    logic        leakage = 1'b0;
    logic [2:0]  leakage_floor = 3'd0;
    logic        req_ready;
    logic        reject;
    logic [2:0]  current_floor;
    logic [15:0] moving;
    logic        busy;
    logic        done;
    logic [2:0]  done_floor;
    logic        stall;
    logic [2:0]  queue_count;
    logic [1:0]  state;

    int checks = 0;
    int errors = 0;
    logic [2:0]  exp_done_q [$];
    logic [15:0] exp_plate_q [$];
    logic [15:0] prev_moving = 16'd0;

    elevator_scheduler #(.QDEPTH(4)) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_type(req_type),
        .req_plate(req_plate), .req_floor(req_floor), .leakage(leakage),
        .leakage_floor(leakage_floor), .req_ready(req_ready), .reject(reject),
        .current_floor(current_floor), .moving(moving), .busy(busy), .done(done),
        .done_floor(done_floor), .stall(stall), .queue_count(queue_count), .state(state)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic offer(input logic t, input logic [15:0] p, input logic [2:0] f);
        req_valid = 1'b1;
        req_type  = t;
        req_plate = p;
        req_floor = f;
    endtask

    task automatic idle_in();
        req_valid = 1'b0;
    endtask

    task automatic expect_job(input logic [15:0] p, input logic [2:0] dfl);
        exp_plate_q.push_back(p);
        exp_done_q.push_back(dfl);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 300 && exp_done_q.size() != 0; i++)
            tick();
        check(name, exp_done_q.size(), 0);
    endtask

    // Monitor: every pickup and every unload must match the next queued expectation.
    always @(negedge clock) begin
        if (reset) begin
            prev_moving = 16'd0;
        end else begin
            if (moving != 16'd0 && prev_moving == 16'd0) begin
                if (exp_plate_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pickup_unexpected: got plate %h, expected none", moving);
                end else begin
                    check("pickup_plate", int'(moving), int'(exp_plate_q.pop_front()));
                end
            end
            if (done) begin
                if (exp_done_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL done_unexpected: got done_floor %0d, expected no done", done_floor);
                end else begin
                    check("done_floor", int'(done_floor), int'(exp_done_q.pop_front()));
                end
            end
            prev_moving = moving;
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation still running at time limit, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tick();
        tick();
        check("rst_state", int'(state), 0);
        check("rst_floor", int'(current_floor), 0);
        check("rst_moving", int'(moving), 0);
        check("rst_count", int'(queue_count), 0);
        check("rst_ready", int'(req_ready), 1);
        check("rst_reject", int'(reject), 0);
        check("rst_done", int'(done), 0);
        check("rst_done_floor", int'(done_floor), 0);
        check("rst_stall", int'(stall), 0);
        check("rst_busy", int'(busy), 0);
        reset = 1'b0;
        tick();

        // Take-out 8754 from floor 2, elevator at floor 0
        offer(1'b1, 16'h8754, 3'd2); expect_job(16'h8754, 3'd0);
        tick(); idle_in();
        check("out_count_e0", int'(queue_count), 1);
        tick(); check("out_state_e1", int'(state), 1);
        tick(); check("out_floor_e2", int'(current_floor), 1);
        tick(); check("out_floor_e3", int'(current_floor), 2);
        tick(); check("out_moving_e4", int'(moving), 16'h8754);
        check("out_state_e4", int'(state), 2);
        tick(); check("out_floor_e5", int'(current_floor), 1);
        tick(); check("out_floor_e6", int'(current_floor), 0);
        tick(); check("out_done_e7", int'(done), 1);
        check("out_done_floor_e7", int'(done_floor), 0);
        check("out_moving_e7", int'(moving), 0);

        // Park-in 9423 to floor 3
        offer(1'b0, 16'h9423, 3'd3); expect_job(16'h9423, 3'd3);
        tick(); idle_in();
        check("in_count_e0", int'(queue_count), 1);
        check("in_state_e0", int'(state), 0);
        tick(); check("in_state_e1", int'(state), 1);
        check("in_count_e1", int'(queue_count), 0);
        check("in_busy_e1", int'(busy), 1);
        tick(); check("in_moving_e2", int'(moving), 16'h9423);
        check("in_floor_e2", int'(current_floor), 0);
        tick(); check("in_floor_e3", int'(current_floor), 1);
        tick(); check("in_floor_e4", int'(current_floor), 2);
        tick(); check("in_floor_e5", int'(current_floor), 3);
        check("in_done_e5", int'(done), 0);
        tick(); check("in_done_e6", int'(done), 1);
        check("in_done_floor_e6", int'(done_floor), 3);
        check("in_moving_e6", int'(moving), 0);
        check("in_state_e6", int'(state), 0);

        // Fill the queue while busy; the fifth offer is ignored
        offer(1'b0, 16'h1111, 3'd7); expect_job(16'h1111, 3'd7);
        tick(); idle_in();
        tick();
        offer(1'b0, 16'h0001, 3'd1); expect_job(16'h0001, 3'd1); tick();
        offer(1'b1, 16'h0002, 3'd2); expect_job(16'h0002, 3'd0); tick();
        offer(1'b0, 16'h0003, 3'd4); expect_job(16'h0003, 3'd4); tick();
        offer(1'b1, 16'h0004, 3'd1); expect_job(16'h0004, 3'd0); tick();
        idle_in();
        check("full_count", int'(queue_count), 4);
        check("full_ready", int'(req_ready), 0);
        check("full_busy", int'(busy), 1);
        offer(1'b0, 16'h0005, 3'd6);
        tick(); idle_in();
        check("full_ignored_count", int'(queue_count), 4);
        check("full_no_reject", int'(reject), 0);
        drain("full_drain");

        // Leak on floor 3 holds a trip to floor 5 at floor 2
        leakage = 1'b1; leakage_floor = 3'd3;
        offer(1'b0, 16'h5858, 3'd5); expect_job(16'h5858, 3'd5);
        tick(); idle_in();
        tick(); tick(); tick();
        tick(); check("leak_floor_e4", int'(current_floor), 2);
        check("leak_stall_e4", int'(stall), 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("leak_hold_floor", int'(current_floor), 2);
            check("leak_hold_stall", int'(stall), 1);
        end
        leakage = 1'b0;
        tick(); check("leak_resume_floor", int'(current_floor), 3);
        check("leak_resume_stall", int'(stall), 0);
        drain("leak_drain");
        check("leak_end_floor", int'(current_floor), 5);

        // Leak on the current floor: loading and leaving it are allowed
        leakage = 1'b1; leakage_floor = 3'd5;
        offer(1'b1, 16'h2929, 3'd5); expect_job(16'h2929, 3'd0);
        tick(); idle_in();
        tick();
        tick(); check("leakhere_moving", int'(moving), 16'h2929);
        check("leakhere_stall", int'(stall), 0);
        tick(); check("leakhere_leave", int'(current_floor), 4);
        check("leakhere_leave_stall", int'(stall), 0);
        drain("leakhere_drain");
        leakage = 1'b0; leakage_floor = 3'd0;

        // Floor-0 request rejected; push and pop together at count 2
        offer(1'b0, 16'h7777, 3'd0);
        tick(); idle_in();
        check("rej_pulse", int'(reject), 1);
        check("rej_count", int'(queue_count), 0);
        check("rej_ready", int'(req_ready), 1);
        tick(); check("rej_clear", int'(reject), 0);
        offer(1'b0, 16'h0101, 3'd2); expect_job(16'h0101, 3'd2); tick();
        offer(1'b1, 16'h0303, 3'd3); expect_job(16'h0303, 3'd0); tick();
        check("pp_count_1", int'(queue_count), 1);
        offer(1'b0, 16'h0404, 3'd1); expect_job(16'h0404, 3'd1); tick();
        idle_in();
        tick(); tick(); tick();
        check("pp_count_idle", int'(queue_count), 2);
        check("pp_state_idle", int'(state), 0);
        offer(1'b1, 16'h0505, 3'd1); expect_job(16'h0505, 3'd0); tick();
        idle_in();
        check("pp_count_2", int'(queue_count), 2);
        check("pp_state_pick", int'(state), 1);
        drain("pp_drain");

        // Reset while carrying a car at floor 4 with a job queued
        offer(1'b0, 16'h0606, 3'd6); exp_plate_q.push_back(16'h0606); tick();
        offer(1'b1, 16'h0707, 3'd3); tick();
        idle_in();
        for (int i = 0; i < 5; i++) tick();
        check("mid_state", int'(state), 2);
        check("mid_floor", int'(current_floor), 4);
        check("mid_count", int'(queue_count), 1);
        reset = 1'b1;
        #1;
        check("arst_state", int'(state), 0);
        check("arst_floor", int'(current_floor), 0);
        check("arst_moving", int'(moving), 0);
        check("arst_count", int'(queue_count), 0);
        check("arst_ready", int'(req_ready), 1);
        check("arst_done", int'(done), 0);
        tick(); tick();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("post_state", int'(state), 0);
        check("post_count", int'(queue_count), 0);
        check("post_floor", int'(current_floor), 0);
        check("post_plates_left", exp_plate_q.size(), 0);
        check("post_done_left", exp_done_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/elevator_scheduler.md
ELEVATOR_SCHEDULER -- requirements
Module: elevator_scheduler

Interface
REQ-001 Parameter: QDEPTH, default 4, request FIFO depth (power of two, >=2).
REQ-002 clock  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req_valid  input  1  request offered this cycle.
REQ-005 req_type  input  1  0 = park-in (floor 0 -> req_floor), 1 = take-out (req_floor -> floor 0).
REQ-006 req_plate  input  16  BCD license plate, 4 digits.
REQ-007 req_floor  input  3  target parking floor, valid range 1..7.
REQ-008 leakage  input  1  leak alarm active.
REQ-009 leakage_floor  input  3  floor under leak; 0 means none.
REQ-010 req_ready  output  1  FIFO not full.
REQ-011 reject  output  1  one-cycle pulse: request with req_floor==0 refused.
REQ-012 current_floor  output  3  elevator position, 0..7.
REQ-013 moving  output  16  plate of car aboard; 0 when empty.
REQ-014 busy  output  1  state != IDLE.
REQ-015 done  output  1  one-cycle pulse on unload.
REQ-016 done_floor  output  3  floor of the last unload; held until the next unload.
REQ-017 stall  output  1  elevator held this cycle by leakage.
REQ-018 queue_count  output  3  number of FIFO entries.
REQ-019 state  output  2  FSM state: IDLE=00, TO_PICK=01, TO_DROP=10.

Function
REQ-020 Accept on rising edge when req_valid & req_ready & req_floor!=0; push {type, plate, pick, drop}: in -> pick 0, drop req_floor; out -> pick req_floor, drop 0.
REQ-021 req_valid with req_floor==0 -> not enqueued; reject=1 next cycle for exactly one cycle; req_ready unaffected.
REQ-022 req_valid while full -> ignored, no reject, count unchanged.
REQ-023 Push and pop on the same edge -> queue_count unchanged; FIFO pointers wrap modulo QDEPTH.
REQ-024 IDLE: if queue_count>0, pop the head and go to TO_PICK on the same edge; otherwise stay.
REQ-025 TO_PICK: current_floor != pick -> step one floor toward pick; current_floor == pick -> moving<=plate, go to TO_DROP.
REQ-026 TO_DROP: current_floor != drop -> step one floor toward drop; current_floor == drop -> moving<=0, done=1, done_floor<=drop, go to IDLE.
REQ-027 current_floor changes by at most 1 per cycle; never leaves 0..7; stays put in IDLE.
REQ-028 Leak hold: leakage=1, leakage_floor!=0 and the next step would enter leakage_floor -> no step, stall=1; stall=0 otherwise.
REQ-029 Leakage never blocks load/unload at the current floor or leaving the leak floor.
REQ-030 A leak hold lasts while the condition holds; the step resumes on the first cycle it clears.
REQ-031 Requests are served strictly FIFO, one at a time; no preemption.
REQ-032 state 11 is unreachable; if entered, return to IDLE next edge.

Reset
REQ-033 reset=1 immediately forces state=IDLE, current_floor=0, moving=0, FIFO empty (queue_count=0), req_ready=1, reject=0, done=0, done_floor=0, stall=0.
REQ-034 Reset mid-operation discards the in-flight request and all queued requests; no done pulse.

Verification
REQ-035 Idle at floor 0; park-in 9423 to floor 3 accepted at edge 0 -> pop/TO_PICK at edge 1; moving=9423 at edge 2; floor 1,2,3 at edges 3-5; done=1, done_floor=3, moving=0 at edge 6.
REQ-036 Take-out 8754 from floor 2 with the elevator at floor 0 -> floor 1,2 at edges 2-3; moving=8754 at edge 4; floor 1,0 at edges 5-6; done, done_floor=0 at edge 7.
REQ-037 Five back-to-back requests with QDEPTH=4 while busy -> req_ready=0 at count 4; 5th ignored; four done pulses in order.
REQ-038 Park-in to floor 5 with leakage=1, leakage_floor=3 -> elevator holds at floor 2 with stall=1; leakage cleared -> continues to 5, done.
REQ-039 req_floor=0 -> reject pulse, queue_count stays 0; push+pop on one edge at count 2 -> count stays 2.
REQ-040 reset asserted in TO_DROP at floor 4 -> current_floor=0, moving=0, count=0 without waiting for a clock edge; no done pulse.
